platform_color_mapper: RTL and testbench

PLATFORM_COLOR_MAPPER -- requirements
Module: platform_color_mapper

---
 rtl/doodle_pkg.sv | 19 +
 rtl/platform_regfile.sv | 81 ++++++++
 rtl/platform_color_mapper.sv | 166 ++++++++++++++++
 tb/tb_platform_color_mapper.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared constants, colours and hit classes for the platform colour mapper.
package doodle_pkg;

    localparam int TILE_W   = 8;
    localparam int TILE_H   = 16;
    localparam int SCREEN_H = 480;

    localparam logic [23:0] COL_PLAYER = 24'h00FFFF;
    localparam logic [23:0] COL_PLAT   = 24'hFFFF00;
    localparam logic [23:0] COL_BG     = 24'hFFFFFF;
    localparam logic [23:0] COL_BLANK  = 24'h000000;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        PLAYER = 2'd1,
        PLAT   = 2'd2
    } hit_e;

endpackage

// File: rtl/platform_regfile.sv
// Per-platform shadow registers (CPU-written) and active registers (used for drawing),
// with a downward scroll applied to both at every frame_start.
module platform_regfile
    import doodle_pkg::*;
#(
    parameter int NUM_PLAT = 8,
    parameter int IDX_W    = 3
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [9:0]                 wr_x,
    input  logic [9:0]                 wr_y,
    input  logic                       wr_on,
    input  logic                       frame_start,
    input  logic [9:0]                 scroll_dy,
    output logic [NUM_PLAT-1:0][9:0]   act_x,
    output logic [NUM_PLAT-1:0][10:0]  act_y,
    output logic [NUM_PLAT-1:0]        act_on
);

    for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_plat
        logic [9:0]  sh_x_q, sh_x_d, ac_x_q, ac_x_d;
        logic [10:0] sh_y_q, sh_y_d, ac_y_q, ac_y_d;
        logic        sh_on_q, sh_on_d, ac_on_q, ac_on_d;
        logic [10:0] scr_y;
        logic        scr_on;
        logic        wr_hit;

        // Out-of-range indices never match any entry, so they are dropped.
        assign wr_hit = wr_en && (int'(wr_idx) == gi);
        assign scr_y  = sh_y_q + {1'b0, scroll_dy};
        assign scr_on = sh_on_q && (scr_y < 11'(SCREEN_H));

        always_comb begin
            sh_x_d  = sh_x_q;
            sh_y_d  = sh_y_q;
            sh_on_d = sh_on_q;
            ac_x_d  = ac_x_q;
            ac_y_d  = ac_y_q;
            ac_on_d = ac_on_q;
            if (frame_start) begin
                sh_y_d  = scr_y;
                sh_on_d = scr_on;
                ac_x_d  = sh_x_q;
                ac_y_d  = scr_y;
                ac_on_d = scr_on;
            end
            // A coincident write lands unscrolled; active still takes the old entry.
            if (wr_hit) begin
                sh_x_d  = wr_x;
                sh_y_d  = {1'b0, wr_y};
                sh_on_d = wr_on;
            end
        end

        always_ff @(posedge clk) begin
            if (srst) begin
                sh_x_q  <= '0;
                sh_y_q  <= '0;
                sh_on_q <= 1'b0;
                ac_x_q  <= '0;
                ac_y_q  <= '0;
                ac_on_q <= 1'b0;
            end else begin
                sh_x_q  <= sh_x_d;
                sh_y_q  <= sh_y_d;
                sh_on_q <= sh_on_d;
                ac_x_q  <= ac_x_d;
                ac_y_q  <= ac_y_d;
                ac_on_q <= ac_on_d;
            end
        end

        assign act_x[gi]  = ac_x_q;
        assign act_y[gi]  = ac_y_q;
        assign act_on[gi] = ac_on_q;
    end

endmodule

// File: rtl/platform_color_mapper.sv
// Three-stage pixel colouring: box hit tests and glyph address, synchronous font ROM,
// then colour selection. RGB for DrawX at cycle N appears at N+3.
module platform_color_mapper
    import doodle_pkg::*;
#(
    parameter int          NUM_PLAT   = 8,
    parameter int          PLAT_TILES = 10,
    parameter logic [6:0]  PLAT_GLYPH = 7'h00,
    localparam int         IDX_W      = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic [9:0]        player_x,
    input  logic [9:0]        player_y,
    input  logic [6:0]        player_glyph,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic              wr_on,
    input  logic [9:0]        scroll_dy,
    output logic [10:0]       rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              rgb_valid
);

    localparam logic [10:0] PLAT_W = 11'(PLAT_TILES * TILE_W);

    logic [NUM_PLAT-1:0][9:0]  act_x;
    logic [NUM_PLAT-1:0][10:0] act_y;
    logic [NUM_PLAT-1:0]       act_on;

    platform_regfile #(
        .NUM_PLAT (NUM_PLAT),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk         (Clk),
        .srst        (Reset),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_on       (wr_on),
        .frame_start (frame_start),
        .scroll_dy   (scroll_dy),
        .act_x       (act_x),
        .act_y       (act_y),
        .act_on      (act_on)
    );

    logic [10:0] px, py, plx, ply;
    logic        player_hit;
    assign px  = {1'b0, DrawX};
    assign py  = {1'b0, DrawY};
    assign plx = {1'b0, player_x};
    assign ply = {1'b0, player_y};
    assign player_hit = (px >= plx) && (px < plx + 11'(TILE_W)) &&
                        (py >= ply) && (py < ply + 11'(TILE_H));

    logic [NUM_PLAT-1:0]      plat_hit;
    logic [NUM_PLAT-1:0][3:0] plat_row;
    logic [NUM_PLAT-1:0][2:0] plat_col;

    // Row and column only need the low bits because they are used solely inside the box.
    for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_hit
        logic [10:0] bx;
        assign bx = {1'b0, act_x[gi]};
        assign plat_hit[gi] = act_on[gi] && (px >= bx) && (px < bx + PLAT_W) &&
                              (py >= act_y[gi]) && (py < act_y[gi] + 11'(TILE_H));
        assign plat_row[gi] = DrawY[3:0] - act_y[gi][3:0];
        assign plat_col[gi] = DrawX[2:0] - act_x[gi][2:0];
    end

    hit_e        s0_hit;
    logic [3:0]  s0_row;
    logic [2:0]  s0_col;
    logic [6:0]  s0_glyph;
    logic        pix_bit;

    hit_e        hit1_q, hit1_d, hit2_q, hit2_d;
    logic [2:0]  col1_q, col1_d, col2_q, col2_d;
    logic        vld1_q, vld1_d, vld2_q, vld2_d;
    logic [10:0] rom_addr_q, rom_addr_d;
    logic [23:0] rgb_q, rgb_d;
    logic        rgb_valid_q, rgb_valid_d;

    always_comb begin
        s0_hit   = NONE;
        s0_row   = '0;
        s0_col   = '0;
        s0_glyph = PLAT_GLYPH;
        // Descending scan so the lowest-index platform wins.
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (plat_hit[i]) begin
                s0_hit = PLAT;
                s0_row = plat_row[i];
                s0_col = plat_col[i];
            end
        end
        if (player_hit) begin
            s0_hit   = PLAYER;
            s0_glyph = player_glyph;
            s0_row   = DrawY[3:0] - player_y[3:0];
            s0_col   = DrawX[2:0] - player_x[2:0];
        end

        rom_addr_d = (s0_hit == NONE) ? 11'd0 : {s0_glyph, s0_row};
        hit1_d     = s0_hit;
        col1_d     = s0_col;
        vld1_d     = pix_valid;

        hit2_d     = hit1_q;
        col2_d     = col1_q;
        vld2_d     = vld1_q;

        pix_bit    = rom_data[3'd7 - col2_q];
        rgb_d      = COL_BLANK;
        if (vld2_q) begin
            if (pix_bit && hit2_q == PLAYER)
                rgb_d = COL_PLAYER;
            else if (pix_bit && hit2_q == PLAT)
                rgb_d = COL_PLAT;
            else
                rgb_d = COL_BG;
        end
        rgb_valid_d = vld2_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit1_q      <= NONE;
            hit2_q      <= NONE;
            col1_q      <= '0;
            col2_q      <= '0;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            rom_addr_q  <= '0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            hit1_q      <= hit1_d;
            hit2_q      <= hit2_d;
            col1_q      <= col1_d;
            col2_q      <= col2_d;
            vld1_q      <= vld1_d;
            vld2_q      <= vld2_d;
            rom_addr_q  <= rom_addr_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign Red       = rgb_q[23:16];
    assign Green     = rgb_q[15:8];
    assign Blue      = rgb_q[7:0];
    assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_platform_color_mapper.sv
// Directed bench for platform_color_mapper with a registered font ROM model.
module tb_platform_color_mapper;

    localparam int NP = 6;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        pix_valid = 1'b0, frame_start = 1'b0;
    logic [9:0]  player_x = 10'd1000, player_y = 10'd1000;
    logic [6:0]  player_glyph = 7'h41;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [9:0]  wr_x = '0, wr_y = '0;
    logic        wr_on = 1'b0;
    logic [9:0]  scroll_dy = '0;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [7:0]  Red, Green, Blue;
    logic        rgb_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] rom [0:2047];

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    platform_color_mapper #(
        .NUM_PLAT   (NP),
        .PLAT_TILES (10),
        .PLAT_GLYPH (7'h00)
    ) dut (
        .Clk          (clk),
        .Reset        (Reset),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .pix_valid    (pix_valid),
        .frame_start  (frame_start),
        .player_x     (player_x),
        .player_y     (player_y),
        .player_glyph (player_glyph),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_on        (wr_on),
        .scroll_dy    (scroll_dy),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .rgb_valid    (rgb_valid)
    );

    typedef struct {
        logic [9:0]  plx, ply, x, y;
        logic [10:0] addr;
        logic [23:0] rgb;
        string       nm;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic plat_write(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                              input logic on);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_on = on;
        @(negedge clk);
        wr_en = 1'b0;
        $display("write idx=%0d x=%0d y=%0d on=%0d", idx, x, y, on);
    endtask

    task automatic frame(input logic [9:0] dy);
        @(negedge clk);
        frame_start = 1'b1; scroll_dy = dy;
        @(negedge clk);
        frame_start = 1'b0;
        $display("frame_start dy=%0d", dy);
    endtask

    // One pixel through the pipe; optionally pulses frame_start in the same cycle.
    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp_rgb,
                       input logic [10:0] exp_addr, input string nm,
                       input bit fs = 1'b0, input logic [9:0] dy = '0);
        @(negedge clk);
        DrawX = x; DrawY = y; pix_valid = 1'b1;
        if (fs) begin
            frame_start = 1'b1; scroll_dy = dy;
        end
        @(negedge clk);
        pix_valid = 1'b0; frame_start = 1'b0;
        chk({nm, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        @(negedge clk);
        @(negedge clk);
        chk({nm, ".rgb"}, {8'h0, Red, Green, Blue}, {8'h0, exp_rgb});
        chk({nm, ".vld"}, 32'(rgb_valid), 32'd1);
        $display("pixel %s (%0d,%0d) addr=%0d rgb=%02h%02h%02h", nm, x, y, rom_addr, Red, Green, Blue);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
        rom[0]    = 8'hFF;
        rom[1]    = 8'h0F;
        rom[2]    = 8'h08;
        rom[4]    = 8'h80;
        rom[5]    = 8'h20;
        rom[15]   = 8'h80;
        rom[1040] = 8'hA0;
        rom[1041] = 8'h01;

        // platform 0 at (240,400); player glyph 0x41 -> base address 1040
        tbl[0]  = '{10'd1000, 10'd1000, 10'd240, 10'd400, 11'd0,    24'hFFFF00, "p0_left"};
        tbl[1]  = '{10'd1000, 10'd1000, 10'd320, 10'd400, 11'd0,    24'hFFFFFF, "p0_past_right"};
        tbl[2]  = '{10'd1000, 10'd1000, 10'd319, 10'd400, 11'd0,    24'hFFFF00, "p0_right"};
        tbl[3]  = '{10'd1000, 10'd1000, 10'd241, 10'd401, 11'd1,    24'hFFFFFF, "p0_row1_c1"};
        tbl[4]  = '{10'd1000, 10'd1000, 10'd247, 10'd401, 11'd1,    24'hFFFF00, "p0_row1_c7"};
        tbl[5]  = '{10'd1000, 10'd1000, 10'd240, 10'd415, 11'd15,   24'hFFFF00, "p0_row15"};
        tbl[6]  = '{10'd1000, 10'd1000, 10'd240, 10'd416, 11'd0,    24'hFFFFFF, "p0_below"};
        tbl[7]  = '{10'd1000, 10'd1000, 10'd239, 10'd400, 11'd0,    24'hFFFFFF, "p0_left_out"};
        tbl[8]  = '{10'd244,  10'd400,  10'd244, 10'd400, 11'd1040, 24'h00FFFF, "pl_bit1"};
        tbl[9]  = '{10'd244,  10'd400,  10'd245, 10'd400, 11'd1040, 24'hFFFFFF, "pl_bit0"};
        tbl[10] = '{10'd244,  10'd400,  10'd246, 10'd400, 11'd1040, 24'h00FFFF, "pl_c2"};
        tbl[11] = '{10'd244,  10'd400,  10'd251, 10'd400, 11'd1040, 24'hFFFFFF, "pl_c7_transp"};
        tbl[12] = '{10'd244,  10'd400,  10'd252, 10'd400, 11'd0,    24'hFFFF00, "pl_right_out"};
        tbl[13] = '{10'd244,  10'd400,  10'd244, 10'd401, 11'd1041, 24'hFFFFFF, "pl_row1"};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.vld", 32'(rgb_valid), 32'd0);
        chk("rst.rgb", {8'h0, Red, Green, Blue}, 32'd0);
        chk("rst.addr", 32'(rom_addr), 32'd0);
        Reset = 1'b0;
        pix(10'd10, 10'd10, 24'hFFFFFF, 11'd0, "rst_bg");
        @(negedge clk);
        chk("idle.vld", 32'(rgb_valid), 32'd0);
        chk("idle.rgb", {8'h0, Red, Green, Blue}, 32'd0);

        // platform draw and priority table
        plat_write(3'd0, 10'd240, 10'd400, 1'b1);
        frame(10'd0);
        for (int i = 0; i < 14; i++) begin
            player_x = tbl[i].plx;
            player_y = tbl[i].ply;
            pix(tbl[i].x, tbl[i].y, tbl[i].rgb, tbl[i].addr, tbl[i].nm);
        end
        player_x = 10'd1000; player_y = 10'd1000;

        // scroll: 470+4 = 474, then +10 = 484 turns the platform off
        plat_write(3'd0, 10'd240, 10'd470, 1'b1);
        frame(10'd4);
        pix(10'd240, 10'd474, 24'hFFFF00, 11'd0, "scr_top");
        pix(10'd240, 10'd473, 24'hFFFFFF, 11'd0, "scr_above");
        pix(10'd240, 10'd478, 24'hFFFF00, 11'd4, "scr_fs_same_cycle", 1'b1, 10'd10);
        pix(10'd240, 10'd478, 24'hFFFFFF, 11'd0, "scr_off");

        // simultaneous write and frame_start on idx 1
        plat_write(3'd1, 10'd100, 10'd100, 1'b1);
        frame(10'd0);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 3'd1; wr_x = 10'd100; wr_y = 10'd200; wr_on = 1'b1;
        frame_start = 1'b1; scroll_dy = 10'd5;
        @(negedge clk);
        wr_en = 1'b0; frame_start = 1'b0;
        $display("write+frame idx=1 y=200 dy=5");
        pix(10'd100, 10'd105, 24'hFFFF00, 11'd0,  "sim_105");
        pix(10'd100, 10'd104, 24'hFFFFFF, 11'd0,  "sim_104");
        pix(10'd100, 10'd120, 24'hFFFF00, 11'd15, "sim_row15");
        pix(10'd100, 10'd121, 24'hFFFFFF, 11'd0,  "sim_121");
        frame(10'd5);
        pix(10'd100, 10'd205, 24'hFFFF00, 11'd0, "sim_205");
        pix(10'd100, 10'd105, 24'hFFFFFF, 11'd0, "sim_old_gone");

        // overlap: platforms 2 and 5 both cover (300,300); lowest index wins
        plat_write(3'd2, 10'd296, 10'd298, 1'b1);
        plat_write(3'd5, 10'd280, 10'd295, 1'b1);
        frame(10'd0);
        pix(10'd300, 10'd300, 24'hFFFF00, 11'd2, "ovl_p2");
        pix(10'd282, 10'd300, 24'hFFFF00, 11'd5, "ovl_p5_only");
        plat_write(3'd6, 10'd0, 10'd0, 1'b1);
        frame(10'd0);
        pix(10'd300, 10'd300, 24'hFFFF00, 11'd2, "ovl_after_bad_idx");
        pix(10'd0,   10'd0,   24'hFFFFFF, 11'd0, "bad_idx_ignored");

        // reset overrides a coincident write and frame_start
        @(negedge clk);
        Reset = 1'b1;
        wr_en = 1'b1; wr_idx = 3'd3; wr_x = 10'd296; wr_y = 10'd298; wr_on = 1'b1;
        frame_start = 1'b1; scroll_dy = 10'd0;
        @(negedge clk);
        Reset = 1'b0; wr_en = 1'b0; frame_start = 1'b0;
        chk("mid_rst.vld", 32'(rgb_valid), 32'd0);
        pix(10'd300, 10'd300, 24'hFFFFFF, 11'd0, "mid_rst_cleared");
        frame(10'd0);
        pix(10'd300, 10'd300, 24'hFFFFFF, 11'd0, "mid_rst_no_write");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
